// File: rtl/jups_fetch_pkg.sv
// rtl/jups_fetch_pkg.sv - shared types and default widths for the instruction fetch stage
package jups_fetch_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetched {pc, instr} entries with flush-style clear
module fetch_queue
  import jups_fetch_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           push,
  input  entry_t         push_data,
  input  logic           pop,
  output entry_t         head_data,
  output logic           empty,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  // clear wins over a same-cycle push or pop; a full queue still accepts a push alongside a pop
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC-driven imem req/ack fetch into a decode queue
module instruction_fetch_unit
  import jups_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_stall,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int             CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;

  logic              can_issue;
  logic              q_push, q_pop, q_empty;
  logic [CNT_W-1:0]  q_count;
  entry_t            q_wdata, q_head;

  // issuing requires a free slot, so an in-flight fetch can always be pushed
  assign can_issue = !flush && (q_count < CNT_DEPTH);
  assign pc_stall  = reset || !((state_q == IDLE) && can_issue);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req_d   = req_q;
    q_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_issue) begin
          addr_d  = pc_in;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          q_push  = !flush;
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // the bus request is never withdrawn; wait out the stale ack
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  assign q_wdata = '{pc: addr_q, instr: imem_rdata};
  assign q_pop   = instr_valid && instr_ready;

  fetch_queue #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_fetch_queue (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .push     (q_push),
    .push_data(q_wdata),
    .pop      (q_pop),
    .head_data(q_head),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = !q_empty;
  assign instr       = q_head.instr;
  assign instr_pc    = q_head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc_in = '0;
  logic          pc_stall;
  logic          flush = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;

  int            errors = 0;
  int            checks = 0;
  logic [AW+DW-1:0] sb[$];

  logic          ack_on = 1'b0;
  int            ack_lat = 0;
  logic          force_en = 1'b0;
  logic [DW-1:0] force_val = '0;
  logic [AW-1:0] flush_target = '0;

  instruction_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_stall   (pc_stall),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ (a * 32'h0001_0003);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int bound, output int cyc);
    cyc = 0;
    while (sb.size() != 0 && cyc < bound) begin
      tick();
      cyc++;
    end
    instr_ready = 1'b0;
  endtask

  task automatic do_reset(input logic [AW-1:0] start_pc);
    reset = 1'b1; instr_ready = 1'b0; flush = 1'b0;
    ack_on = 1'b0; ack_lat = 0; force_en = 1'b0;
    pc_in = start_pc;
    sb.delete();
    tick(); tick();
    reset = 1'b0;
  endtask

  // instruction memory responder
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req === 1'b1 && ack_on) begin
        if (wait_cnt >= ack_lat) begin imem_ack = 1'b1; wait_cnt = 0; end
        else begin imem_ack = 1'b0; wait_cnt++; end
      end else begin
        imem_ack = 1'b0; wait_cnt = 0;
      end
      imem_rdata = force_en ? force_val : word_of(imem_addr);
    end
  end

  // PC model: advances only when pc_stall is low, jumps on flush; each advance must be a fetch of the old PC
  initial begin : pc_model
    logic adv, ld, req_prev;
    logic [AW-1:0] old_pc;
    forever begin
      @(negedge clk);
      #4;
      adv = !reset && (pc_stall === 1'b0);
      ld = flush;
      req_prev = imem_req;
      old_pc = pc_in;
      @(posedge clk);
      #1;
      if (adv) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== old_pc) begin
          errors++;
          $display("FAIL issue_addr: imem_req=%b imem_addr=%h, required req=1 addr=%h", imem_req, imem_addr, old_pc);
        end
      end else if (imem_req === 1'b1 && req_prev !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL spurious_issue: imem_req rose at addr=%h with pc_stall high, required no issue", imem_addr);
      end
      if (ld) pc_in = flush_target;
      else if (adv) pc_in = pc_in + 1;
    end
  end

  // decode side: every accepted head is checked against the scoreboard
  initial begin : monitor
    logic [AW+DW-1:0] exp_e;
    forever begin
      @(negedge clk);
      #4;
      if (!reset && !flush && instr_valid === 1'b1 && instr_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: instr_pc=%h instr=%h, required no entry", instr_pc, instr);
        end else begin
          exp_e = sb.pop_front();
          if ({instr_pc, instr} !== exp_e) begin
            errors++;
            $display("FAIL pop_entry: instr_pc=%h instr=%h, required pc=%h instr=%h",
                     instr_pc, instr, exp_e[AW+DW-1:DW], exp_e[DW-1:0]);
          end
        end
      end
    end
  end

  task automatic test_reset();
    tick(); tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b, required 0", imem_req); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL rst_addr: got %h, required 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", instr_valid); end
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b, required 1", pc_stall); end
    checks++; if (instr !== '0) begin errors++; $display("FAIL rst_instr: got %h, required 0", instr); end
    checks++; if (instr_pc !== '0) begin errors++; $display("FAIL rst_instr_pc: got %h, required 0", instr_pc); end
  endtask

  task automatic test_stream();
    int cyc;
    do_reset('0);
    instr_ready = 1'b1; ack_on = 1'b1; ack_lat = 0;
    for (int i = 0; i < 8; i++) sb.push_back({AW'(i), word_of(AW'(i))});
    wait_drain(100, cyc);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_drain: %0d left, required 0", sb.size()); end
    checks++; if (cyc != 17) begin errors++; $display("FAIL stream_timing: %0d cycles, required 17", cyc); end
  endtask

  task automatic test_backpressure();
    int cyc;
    do_reset('0);
    ack_on = 1'b1; ack_lat = 0;
    repeat (12) tick();
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL bp_stall: got %b, required 1", pc_stall); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b, required 0", imem_req); end
    checks++; if (pc_in !== AW'(4)) begin errors++; $display("FAIL bp_issued: pc_in=%h, required 4", pc_in); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== '0) begin
      errors++; $display("FAIL bp_head: valid=%b pc=%h, required 1/0", instr_valid, instr_pc); end
    for (int i = 0; i < 4; i++) sb.push_back({AW'(i), word_of(AW'(i))});
    instr_ready = 1'b1;
    wait_drain(20, cyc);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: %0d left, required 0", sb.size()); end
  endtask

  task automatic test_flush_in_req();
    int cyc;
    do_reset(AW'(32'h10));
    ack_on = 1'b1; ack_lat = 3; force_en = 1'b1; force_val = 32'hDEADBEEF; instr_ready = 1'b1;
    tick();
    flush = 1'b1; flush_target = AW'(32'h40);
    tick();
    flush = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== AW'(32'h10)) begin
      errors++; $display("FAIL drop_hold: req=%b addr=%h, required 1/00000010", imem_req, imem_addr); end
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drop_hold2: req=%b, required 1", imem_req); end
    ack_lat = 0; force_en = 1'b0;
    sb.push_back({AW'(32'h40), word_of(AW'(32'h40))});
    tick();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL drop_done: req=%b valid=%b, required 0/0", imem_req, instr_valid); end
    wait_drain(10, cyc);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL drop_target: %0d left, required 0", sb.size()); end
  endtask

  task automatic test_flush_ack_pop();
    int cyc;
    do_reset('0);
    ack_on = 1'b1; ack_lat = 0;
    repeat (5) tick();
    checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b1) begin
      errors++; $display("FAIL fap_pre: req=%b valid=%b, required 1/1", imem_req, instr_valid); end
    instr_ready = 1'b1; flush = 1'b1; flush_target = AW'(32'h80);
    sb.push_back({AW'(32'h80), word_of(AW'(32'h80))});
    tick();
    flush = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL fap_post: valid=%b req=%b, required 0/0", instr_valid, imem_req); end
    wait_drain(10, cyc);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL fap_target: %0d left, required 0", sb.size()); end
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset(AW'(4));
    ack_on = 1'b1; ack_lat = 0;
    repeat (10) tick();
    checks++; if (pc_stall !== 1'b1 || instr_pc !== AW'(4) || pc_in !== AW'(8)) begin
      errors++; $display("FAIL wrap_full: stall=%b head=%h pc_in=%h, required 1/4/8", pc_stall, instr_pc, pc_in); end
    for (int i = 4; i < 12; i++) sb.push_back({AW'(i), word_of(AW'(i))});
    instr_ready = 1'b1;
    wait_drain(40, cyc);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d left, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid_fetch();
    int cyc;
    do_reset(AW'(32'h20));
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== AW'(32'h20)) begin
      errors++; $display("FAIL rmf_req: req=%b addr=%h, required 1/00000020", imem_req, imem_addr); end
    reset = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_stall !== 1'b1) begin
      errors++; $display("FAIL rmf_reset: req=%b valid=%b stall=%b, required 0/0/1", imem_req, instr_valid, pc_stall); end
    pc_in = AW'(32'h30);
    tick();
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL rmf_stall: got %b, required 1", pc_stall); end
    reset = 1'b0; ack_on = 1'b1; ack_lat = 0; instr_ready = 1'b1;
    sb.push_back({AW'(32'h30), word_of(AW'(32'h30))});
    wait_drain(10, cyc);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rmf_after: %0d left, required 0", sb.size()); end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_in_req();
    test_flush_ack_pop();
    test_wrap();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
